sram_bank_arbiter: RTL and testbench

SRAM_BANK_ARBITER -- requirements
Module: sram_bank_arbiter

---
 rtl/tpc_sram_pkg.sv | 32 +++
 rtl/sram_bank_arbiter_rr_arbiter.sv | 62 ++++++
 rtl/sram_bank_arbiter.sv | 122 ++++++++++++
 tb/tb_sram_bank_arbiter.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tpc_sram_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tpc_sram_pkg
// Description : Shared SRAM constants, bank/word address mapping and the
//               read-tag type used by the arbiter, SRAM and DMA blocks.
// Revision    : 1.0 - initial release
// ============================================================================
package tpc_sram_pkg;

    localparam int SRAM_NUM_BANKS = 4;
    localparam int SRAM_WORD_W    = 8;

    typedef logic [1:0] bank_idx_t;

    // Outstanding read: which bank's data to return next cycle.
    typedef struct packed {
        logic      valid;
        bank_idx_t bank;
    } rd_tag_t;

    // Bank select: low address bits folded with bits [9:8] so that strided
    // walks of 256 words spread across banks instead of hammering one.
    function automatic bank_idx_t bank_of(input logic [9:0] addr);
        return addr[1:0] ^ addr[9:8];
    endfunction

    function automatic logic [SRAM_WORD_W-1:0] word_of(input logic [9:0] addr);
        return addr[9:2];
    endfunction

endpackage
`default_nettype wire

// File: rtl/sram_bank_arbiter_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter
// Description : N-wide round-robin arbiter. Search starts at the registered
//               pointer and wraps; pointer moves past the winner on a grant.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic [N-1:0]                         req,
    output logic [N-1:0]                         gnt,
    output logic [((N > 1) ? $clog2(N) : 1)-1:0] gnt_idx,
    output logic                                 gnt_valid
);

    localparam int               IDX_W  = (N > 1) ? $clog2(N) : 1;
    localparam logic [IDX_W-1:0] c_LAST = IDX_W'(N - 1);

    logic [IDX_W-1:0] r_ptr;
    logic [IDX_W-1:0] w_idx;
    logic             w_found;

    // First requester at or after the pointer, wrapping modulo N.
    always_comb begin
        int pos;
        w_found = 1'b0;
        w_idx   = '0;
        pos     = 0;
        for (int i = 0; i < N; i++) begin
            pos = (int'(r_ptr) + i) % N;
            if (!w_found && req[pos]) begin
                w_found = 1'b1;
                w_idx   = IDX_W'(pos);
            end
        end
    end

    // One-hot grant vector derived from the winning index.
    always_comb begin
        gnt = '0;
        if (w_found) begin
            gnt[w_idx] = 1'b1;
        end
    end

    assign gnt_idx   = w_idx;
    assign gnt_valid = w_found;

    // Pointer advances to the requester after the winner; holds when idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= '0;
        end else if (w_found) begin
            r_ptr <= (w_idx == c_LAST) ? '0 : w_idx + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/sram_bank_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : sram_bank_arbiter
// Description : Routes NUM_REQ requesters onto 4 SRAM banks, one round-robin
//               arbiter per bank, 1-cycle read return, stall-cycle counter.
// Revision    : 1.0 - initial release
// ============================================================================
module sram_bank_arbiter
    import tpc_sram_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int NUM_BANKS = 4,
    parameter int ADDR_W    = 20,
    parameter int DATA_W    = 256,
    parameter int WORD_W    = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ-1:0]            req_we,
    input  logic [NUM_REQ*ADDR_W-1:0]     req_addr,
    input  logic [NUM_REQ*DATA_W-1:0]     req_wdata,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic [NUM_REQ-1:0]            rsp_valid,
    output logic [NUM_REQ*DATA_W-1:0]     rsp_rdata,
    output logic [NUM_BANKS-1:0]          bank_en,
    output logic [NUM_BANKS-1:0]          bank_we,
    output logic [NUM_BANKS*WORD_W-1:0]   bank_addr,
    output logic [NUM_BANKS*DATA_W-1:0]   bank_wdata,
    input  logic [NUM_BANKS*DATA_W-1:0]   bank_rdata,
    output logic [31:0]                   conflict_cnt
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    bank_idx_t          w_req_bank [NUM_REQ];
    logic [WORD_W-1:0]  w_req_word [NUM_REQ];
    logic [NUM_REQ-1:0] w_gnt_all  [NUM_BANKS];
    logic [IDX_W-1:0]   w_gnt_idx  [NUM_BANKS];
    logic [NUM_BANKS-1:0] w_gnt_vld;
    logic [NUM_REQ-1:0] w_ready;
    logic               w_stall;
    rd_tag_t            r_tag      [NUM_REQ];
    logic [31:0]        r_conflict_cnt;

    // Per-requester address decode and response return path.
    generate
        for (genvar r = 0; r < NUM_REQ; r++) begin : g_req
            assign w_req_bank[r] = bank_of(req_addr[r*ADDR_W +: 10]);
            assign w_req_word[r] = WORD_W'(word_of(req_addr[r*ADDR_W +: 10]));
            assign rsp_valid[r]  = r_tag[r].valid;
            assign rsp_rdata[r*DATA_W +: DATA_W] =
                bank_rdata[r_tag[r].bank*DATA_W +: DATA_W];
        end
    endgenerate

    // Per-bank arbitration and SRAM port drive.
    generate
        for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
            logic [NUM_REQ-1:0] w_bank_req;

            for (genvar r = 0; r < NUM_REQ; r++) begin : g_match
                assign w_bank_req[r] = req_valid[r] && (w_req_bank[r] == bank_idx_t'(b));
            end

            rr_arbiter #(
                .N (NUM_REQ)
            ) u_rr (
                .clk       (clk),
                .rst_n     (rst_n),
                .req       (w_bank_req),
                .gnt       (w_gnt_all[b]),
                .gnt_idx   (w_gnt_idx[b]),
                .gnt_valid (w_gnt_vld[b])
            );

            assign bank_en[b] = w_gnt_vld[b];
            assign bank_we[b] = w_gnt_vld[b] & req_we[w_gnt_idx[b]];
            assign bank_addr[b*WORD_W +: WORD_W]  = w_req_word[w_gnt_idx[b]];
            assign bank_wdata[b*DATA_W +: DATA_W] =
                req_wdata[w_gnt_idx[b]*DATA_W +: DATA_W];
        end
    endgenerate

    // A requester is ready when the bank it addresses granted it.
    always_comb begin
        w_ready = '0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            w_ready = w_ready | w_gnt_all[b];
        end
    end

    assign req_ready = w_ready;
    assign w_stall   = |(req_valid & ~w_ready);

    // Capture read tags for accepted reads; data returns next cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NUM_REQ; r++) begin
                r_tag[r] <= '0;
            end
        end else begin
            for (int r = 0; r < NUM_REQ; r++) begin
                r_tag[r].valid <= req_valid[r] & w_ready[r] & ~req_we[r];
                r_tag[r].bank  <= w_req_bank[r];
            end
        end
    end

    // Saturating count of cycles in which any requester was stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_conflict_cnt <= '0;
        end else if (w_stall && (r_conflict_cnt != 32'hFFFF_FFFF)) begin
            r_conflict_cnt <= r_conflict_cnt + 32'd1;
        end
    end

    assign conflict_cnt = r_conflict_cnt;

endmodule
`default_nettype wire

// File: tb/tb_sram_bank_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_sram_bank_arbiter
// Description : Directed and random stimulus for sram_bank_arbiter against a
//               flat-memory reference model with per-bank rotating priority.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sram_bank_arbiter;

    localparam int NR = 4;
    localparam int NB = 4;
    localparam int AW = 20;
    localparam int DW = 256;
    localparam int WW = 8;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NR-1:0]     req_valid;
    logic [NR-1:0]     req_we;
    logic [NR*AW-1:0]  req_addr;
    logic [NR*DW-1:0]  req_wdata;
    logic [NR-1:0]     req_ready;
    logic [NR-1:0]     rsp_valid;
    logic [NR*DW-1:0]  rsp_rdata;
    logic [NB-1:0]     bank_en;
    logic [NB-1:0]     bank_we;
    logic [NB*WW-1:0]  bank_addr;
    logic [NB*DW-1:0]  bank_wdata;
    logic [NB*DW-1:0]  bank_rdata;
    logic [31:0]       conflict_cnt;

    always #5 clk = ~clk;

    sram_bank_arbiter #(
        .NUM_REQ   (NR),
        .NUM_BANKS (NB),
        .ADDR_W    (AW),
        .DATA_W    (DW),
        .WORD_W    (WW)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_we       (req_we),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .req_ready    (req_ready),
        .rsp_valid    (rsp_valid),
        .rsp_rdata    (rsp_rdata),
        .bank_en      (bank_en),
        .bank_we      (bank_we),
        .bank_addr    (bank_addr),
        .bank_wdata   (bank_wdata),
        .bank_rdata   (bank_rdata),
        .conflict_cnt (conflict_cnt)
    );

    // Four synchronous SRAM banks; cleared while reset is held.
    logic [DW-1:0] sram [NB][256];
    always @(posedge clk) begin
        if (!rst_n) begin
            for (int b = 0; b < NB; b++)
                for (int w = 0; w < 256; w++)
                    sram[b][w] <= '0;
        end else begin
            for (int b = 0; b < NB; b++) begin
                if (bank_en[b]) begin
                    if (bank_we[b])
                        sram[b][bank_addr[b*WW +: WW]] <= bank_wdata[b*DW +: DW];
                    else
                        bank_rdata[b*DW +: DW] <= sram[b][bank_addr[b*WW +: WW]];
                end
            end
        end
    end

    // Reference model: one flat 1024-word memory plus rotating priorities.
    int            n_assert;
    int            n_fail;
    int            mptr   [NB];
    bit            pend_v [NR];
    logic [DW-1:0] pend_d [NR];
    logic [31:0]   mcnt;
    logic [DW-1:0] ref_mem [1024];
    logic [NR-1:0] last_rdy;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [AW-1:0] addr_of(input int r);
        return req_addr[r*AW +: AW];
    endfunction

    function automatic int bank_for(input logic [AW-1:0] a);
        return int'(a[1:0] ^ a[9:8]);
    endfunction

    task automatic model_reset();
        for (int b = 0; b < NB; b++) mptr[b] = 0;
        for (int r = 0; r < NR; r++) pend_v[r] = 1'b0;
        for (int i = 0; i < 1024; i++) ref_mem[i] = '0;
        mcnt     = '0;
        last_rdy = '0;
    endtask

    task automatic clear_reqs();
        req_valid = '0;
        req_we    = '0;
        req_addr  = '0;
        req_wdata = '0;
    endtask

    task automatic set_req(input int r, input bit v, input bit we,
                           input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_valid[r]           = v;
        req_we[r]              = we;
        req_addr[r*AW +: AW]   = a;
        req_wdata[r*DW +: DW]  = d;
    endtask

    // Check one clock cycle: combinational grant outputs before the edge,
    // then read responses and the stall counter just after it.
    task automatic cycle(input bit rst_after);
        int            g [NB];
        logic [NR-1:0] er;
        logic [AW-1:0] a;
        #1;
        er = '0;
        for (int b = 0; b < NB; b++) begin
            g[b] = -1;
            for (int i = 0; i < NR; i++) begin
                int r;
                r = (mptr[b] + i) % NR;
                if (g[b] < 0 && req_valid[r] && bank_for(addr_of(r)) == b) g[b] = r;
            end
            if (g[b] >= 0) er[g[b]] = 1'b1;
        end
        chk("req_ready", DW'(req_ready), DW'(er));
        for (int b = 0; b < NB; b++) begin
            chk("bank_en", DW'(bank_en[b]), DW'(g[b] >= 0));
            if (g[b] >= 0) begin
                a = addr_of(g[b]);
                chk("bank_we", DW'(bank_we[b]), DW'(req_we[g[b]]));
                chk("bank_addr", DW'(bank_addr[b*WW +: WW]), DW'(a[9:2]));
                if (req_we[g[b]])
                    chk("bank_wdata", bank_wdata[b*DW +: DW], req_wdata[g[b]*DW +: DW]);
            end
        end
        @(posedge clk);
        if (|(req_valid & ~er) && mcnt != 32'hFFFF_FFFF) mcnt = mcnt + 1;
        for (int r = 0; r < NR; r++) pend_v[r] = 1'b0;
        for (int b = 0; b < NB; b++) begin
            if (g[b] >= 0) begin
                mptr[b] = (g[b] + 1) % NR;
                a = addr_of(g[b]);
                if (req_we[g[b]]) begin
                    ref_mem[a[9:0]] = req_wdata[g[b]*DW +: DW];
                end else begin
                    pend_v[g[b]] = 1'b1;
                    pend_d[g[b]] = ref_mem[a[9:0]];
                end
            end
        end
        last_rdy = er;
        if (rst_after) begin
            rst_n = 1'b0;
            model_reset();
        end
        #1;
        begin
            logic [NR-1:0] ev;
            for (int r = 0; r < NR; r++) ev[r] = pend_v[r];
            chk("rsp_valid", DW'(rsp_valid), DW'(ev));
        end
        for (int r = 0; r < NR; r++)
            if (pend_v[r]) chk("rsp_rdata", rsp_rdata[r*DW +: DW], pend_d[r]);
        chk("conflict_cnt", DW'(conflict_cnt), DW'(mcnt));
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clear_reqs();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("rst_cnt", DW'(conflict_cnt), '0);
        chk("rst_rsp_valid", DW'(rsp_valid), '0);
    endtask

    initial begin
        logic [DW-1:0] pat;
        logic [AW-1:0] ra;
        n_assert = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        clear_reqs();
        do_reset();

        // Four reads to 0x20..0x23 land on four different banks.
        for (int r = 0; r < NR; r++) set_req(r, 1'b1, 1'b0, AW'(32'h20 + r), '0);
        cycle(1'b0);
        chk("all_rsp", DW'(rsp_valid), DW'(4'hF));
        chk("no_conflict", DW'(conflict_cnt), '0);
        clear_reqs();
        cycle(1'b0);

        // Two requesters collide on bank 0; loser waits one cycle.
        do_reset();
        set_req(0, 1'b1, 1'b0, AW'(32'h20), '0);
        set_req(1, 1'b1, 1'b0, AW'(32'h20), '0);
        cycle(1'b0);
        set_req(0, 1'b0, 1'b0, '0, '0);
        cycle(1'b0);
        chk("two_way_cnt", DW'(conflict_cnt), DW'(32'd1));
        clear_reqs();
        cycle(1'b0);

        // Four requesters hammer bank 0 for eight cycles.
        do_reset();
        for (int r = 0; r < NR; r++) set_req(r, 1'b1, 1'b0, AW'(32'h20 + 4*r), '0);
        for (int i = 0; i < 8; i++) begin
            cycle(1'b0);
            chk("rr_order", DW'(last_rdy), DW'(4'b0001 << (i % 4)));
        end
        chk("four_way_cnt", DW'(conflict_cnt), DW'(32'd8));
        clear_reqs();
        cycle(1'b0);

        // Write then read back through bank 1, word 72.
        do_reset();
        pat = {32{8'hA5}};
        set_req(0, 1'b1, 1'b1, AW'(32'h120), pat);
        cycle(1'b0);
        clear_reqs();
        set_req(1, 1'b1, 1'b0, AW'(32'h120), '0);
        cycle(1'b0);
        chk("wr_rd_data", rsp_rdata[1*DW +: DW], pat);
        chk("wr_no_rsp0", DW'(rsp_valid[0]), '0);
        clear_reqs();
        cycle(1'b0);

        // Reset lands between acceptance and response; read is dropped.
        do_reset();
        set_req(1, 1'b1, 1'b0, AW'(32'h21), '0);
        cycle(1'b1);
        clear_reqs();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("post_rst_cnt", DW'(conflict_cnt), '0);
        chk("post_rst_rsp", DW'(rsp_valid), '0);
        set_req(1, 1'b1, 1'b0, AW'(32'h21), '0);
        set_req(2, 1'b1, 1'b0, AW'(32'h25), '0);
        cycle(1'b0);
        chk("post_rst_ptr", DW'(last_rdy), DW'(4'b0010));
        clear_reqs();
        cycle(1'b0);

        // Random traffic; stalled requesters hold their request unchanged.
        do_reset();
        for (int n = 0; n < 300; n++) begin
            for (int r = 0; r < NR; r++) begin
                if (!(req_valid[r] && !last_rdy[r])) begin
                    ra = AW'($urandom);
                    ra[9:0] = 10'($urandom_range(0, 1023)) & 10'h30F;
                    set_req(r, $urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0, ra,
                            {$urandom, $urandom, $urandom, $urandom,
                             $urandom, $urandom, $urandom, $urandom});
                end
            end
            cycle(1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
